// File: rtl/norm_round_pipe_if.sv
// Handshake bundle for norm_round_pipe. The upstream multiplier and downstream
// adder share one bundle: master is the side feeding beats in and draining
// results, slave is the normaliser itself.
interface norm_round_pipe_if #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
);
    // Upstream beat
    logic                         RND_MODE;
    logic                         IN_VALID;
    logic                         IN_READY;
    logic                         IN_SIGN;
    logic signed [EXP_W+1:0]      IN_EXP_A;
    logic signed [EXP_W+1:0]      IN_EXP_B;
    logic [2*(MAN_W+1)-1:0]       IN_SIG_MUL;

    // Downstream result
    logic                         OUT_VALID;
    logic                         OUT_READY;
    logic                         OUT_SIGN;
    logic [EXP_W-1:0]             OUT_EXP;
    logic [MAN_W-1:0]             OUT_MAN;
    logic [3:0]                   OUT_FLAGS;

    modport master (
        output RND_MODE, IN_VALID, IN_SIGN, IN_EXP_A, IN_EXP_B, IN_SIG_MUL, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_SIGN, OUT_EXP, OUT_MAN, OUT_FLAGS
    );

    modport slave (
        input  RND_MODE, IN_VALID, IN_SIGN, IN_EXP_A, IN_EXP_B, IN_SIG_MUL, OUT_READY,
        output IN_READY, OUT_VALID, OUT_SIGN, OUT_EXP, OUT_MAN, OUT_FLAGS
    );
endinterface

// File: rtl/norm_round_pipe.sv
// Two-stage product normaliser for the MAC PE: stage 1 normalises the raw
// significand product and denormalises into the subnormal range, stage 2
// rounds (RNE or truncate) and encodes the biased result plus flags.
// OUT_FLAGS = {OVF, UNF_ZERO, SUB, INEXACT}.
module norm_round_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input logic              CLK,
    input logic              RST,
    norm_round_pipe_if.slave bus
);
    localparam int unsigned SW  = MAN_W + 1;      // significand with hidden bit
    localparam int unsigned PW  = 2 * SW;         // raw product width
    localparam int unsigned NW  = SW + 2;         // significand + guard + round
    localparam int unsigned EW  = EXP_W + 3;      // internal signed exponent
    localparam int unsigned IW  = EXP_W + 2;      // operand exponent width
    localparam int unsigned SHW = $clog2(NW + 1);
    localparam int          BIAS = (2 ** (EXP_W - 1)) - 1;

    localparam logic [EW-1:0] MIN_E  = EW'(1 - BIAS);
    localparam logic [EW:0]   BIAS_X = (EW + 1)'(BIAS);
    localparam logic [EW:0]   NW_X   = (EW + 1)'(NW);

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    logic v1_q, v2_q;
    logic ld1, ld2, accept;

    // Pipeline advance: each stage loads when empty or when its successor moves
    always_comb begin
        ld2    = !v2_q | bus.OUT_READY;
        ld1    = !v1_q | ld2;
        accept = bus.IN_VALID & ld1;
    end

    assign bus.IN_READY = ld1;

    // ---------------------------------------------------------------------
    // Stage 1: normalise / denormalise
    // ---------------------------------------------------------------------
    logic            msb;
    logic [EW-1:0]   e_raw;
    logic [EW:0]     d_full;
    logic            under;
    logic [SHW-1:0]  shamt;
    logic [NW-1:0]   norm, lost_mask;
    logic            low_sticky;
    logic [EW-1:0]   s1_exp_d;
    logic [NW-1:0]   s1_sig_d;
    logic            s1_sticky_d;

    logic            s1_sign_q, s1_rnd_q, s1_zero_q, s1_sticky_q;
    logic [EW-1:0]   s1_exp_q;
    logic [NW-1:0]   s1_sig_q;

    // Align product to 1.x, then shift right into the subnormal range if needed
    always_comb begin
        msb   = bus.IN_SIG_MUL[PW-1];
        e_raw = {bus.IN_EXP_A[IW-1], bus.IN_EXP_A} + {bus.IN_EXP_B[IW-1], bus.IN_EXP_B}
              + EW'(msb);

        if (msb) begin
            norm       = bus.IN_SIG_MUL[PW-1 -: NW];
            low_sticky = |bus.IN_SIG_MUL[PW-NW-1:0];
        end else begin
            norm       = bus.IN_SIG_MUL[PW-2 -: NW];
            low_sticky = |bus.IN_SIG_MUL[PW-NW-2:0];
        end

        under  = $signed(e_raw) < $signed(MIN_E);
        // One extra bit so the distance cannot wrap for the most negative e
        d_full = {MIN_E[EW-1], MIN_E} - {e_raw[EW-1], e_raw};
        shamt  = '0;
        if (under) begin
            shamt = (d_full > NW_X) ? SHW'(NW) : d_full[SHW-1:0];
        end

        lost_mask   = ~({NW{1'b1}} << shamt);
        s1_sig_d    = norm >> shamt;
        s1_sticky_d = low_sticky | (|(norm & lost_mask));
        s1_exp_d    = under ? MIN_E : e_raw;
    end

    // Stage 1 register; data only captured on an accepted beat
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q        <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rnd_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= '0;
            s1_sig_q    <= '0;
        end else if (ld1) begin
            v1_q <= accept;
            if (accept) begin
                s1_sign_q   <= bus.IN_SIGN;
                s1_rnd_q    <= bus.RND_MODE;
                s1_zero_q   <= (bus.IN_SIG_MUL == '0);
                s1_sticky_q <= s1_sticky_d;
                s1_exp_q    <= s1_exp_d;
                s1_sig_q    <= s1_sig_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: round / encode
    // ---------------------------------------------------------------------
    logic [SW-1:0]    sig_v, sig_r;
    logic             g_bit, r_bit, inc, inexact, carry, ovf;
    logic [SW:0]      sum;
    logic [EW:0]      exp_r;
    logic [EXP_W-1:0] o_exp_d;
    logic [MAN_W-1:0] o_man_d;
    logic [3:0]       o_flags_d;

    logic             o_sign_q;
    logic [EXP_W-1:0] o_exp_q;
    logic [MAN_W-1:0] o_man_q;
    logic [3:0]       o_flags_q;

    // Round, renormalise on carry, then pick zero / overflow / normal / subnormal
    always_comb begin
        sig_v   = s1_sig_q[NW-1:2];
        g_bit   = s1_sig_q[1];
        r_bit   = s1_sig_q[0];
        inexact = g_bit | r_bit | s1_sticky_q;
        inc     = !s1_rnd_q & g_bit & (r_bit | s1_sticky_q | sig_v[0]);
        sum     = {1'b0, sig_v} + (SW + 1)'(inc);
        carry   = sum[SW];
        sig_r   = carry ? sum[SW:1] : sum[SW-1:0];
        exp_r   = {s1_exp_q[EW-1], s1_exp_q} + (EW + 1)'(carry);
        // exp_r >= pre-round exponent, so this covers both overflow cases
        ovf     = $signed(exp_r) > $signed(BIAS_X);

        o_exp_d   = '0;
        o_man_d   = '0;
        o_flags_d = '0;
        if (!s1_zero_q) begin
            if (ovf) begin
                o_exp_d   = '1;
                o_flags_d = 4'b1001;
            end else if (sig_r[SW-1]) begin
                // Hidden bit set: normal, including a subnormal that rounded up
                o_exp_d   = EXP_W'(exp_r + BIAS_X);
                o_man_d   = sig_r[MAN_W-1:0];
                o_flags_d = {3'b000, inexact};
            end else begin
                o_man_d   = sig_r[MAN_W-1:0];
                o_flags_d = {1'b0, sig_r == '0, sig_r != '0, inexact};
            end
        end
    end

    // Output register; holds while the downstream stalls
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v2_q      <= 1'b0;
            o_sign_q  <= 1'b0;
            o_exp_q   <= '0;
            o_man_q   <= '0;
            o_flags_q <= '0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                o_sign_q  <= s1_sign_q;
                o_exp_q   <= o_exp_d;
                o_man_q   <= o_man_d;
                o_flags_q <= o_flags_d;
            end
        end
    end

    assign bus.OUT_VALID = v2_q;
    assign bus.OUT_SIGN  = o_sign_q;
    assign bus.OUT_EXP   = o_exp_q;
    assign bus.OUT_MAN   = o_man_q;
    assign bus.OUT_FLAGS = o_flags_q;

endmodule

// File: tb/tb_norm_round_pipe.sv
// Bench for norm_round_pipe (fp16 configuration): directed corner cases,
// backpressure, mid-flight reset and randomized beats against a value-level
// reference model.
module tb_norm_round_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int SW    = MAN_W + 1;
    localparam int PW    = 2 * SW;
    localparam int BIAS  = 15;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expo;
        logic [MAN_W-1:0] man;
        logic [3:0]       flags;
    } res_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    norm_round_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    res_t exp_q[$];
    res_t pend;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_out  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
        end
    endtask

    // Exact value is sig * 2^(a+b-2*MAN_W); round it to an integer count of
    // result ulps, where the ulp is 2^(max(top exponent, 1-BIAS) - MAN_W).
    function automatic res_t ref_model(input logic sgn, input int a, input int b,
                                       input longint sig, input logic rnd);
        res_t   r;
        int     e_top, eff, k;
        longint n, rem, half;
        logic   inexact;
        r.sign  = sgn;
        r.expo  = '0;
        r.man   = '0;
        r.flags = '0;
        if (sig == 0) return r;
        e_top = a + b + ((sig >= (longint'(1) << (PW - 1))) ? 1 : 0);
        eff   = (e_top < 1 - BIAS) ? 1 - BIAS : e_top;
        k     = eff - MAN_W - (a + b - 2 * MAN_W);
        if (k > 40) k = 40;
        n       = sig >> k;
        rem     = sig - (n << k);
        half    = longint'(1) << (k - 1);
        inexact = (rem != 0);
        if (!rnd && (rem > half || (rem == half && n[0]))) n++;
        if (n == (longint'(1) << SW)) begin
            n = n >> 1;
            eff++;
        end
        if (eff > BIAS) begin
            r.expo  = '1;
            r.flags = 4'b1001;
        end else if (n >= (longint'(1) << MAN_W)) begin
            r.expo  = EXP_W'(eff + BIAS);
            r.man   = MAN_W'(n);
            r.flags = {3'b000, inexact};
        end else begin
            r.man   = MAN_W'(n);
            r.flags = {1'b0, n == 0, n != 0, inexact};
        end
        return r;
    endfunction

    task automatic drive(input logic sgn, input int a, input int b,
                         input logic [PW-1:0] sig, input logic rnd);
        bus.IN_SIGN    = sgn;
        bus.IN_EXP_A   = a[EXP_W+1:0];
        bus.IN_EXP_B   = b[EXP_W+1:0];
        bus.IN_SIG_MUL = sig;
        bus.RND_MODE   = rnd;
        bus.IN_VALID   = 1'b1;
        pend = ref_model(sgn, a, b, longint'(sig), rnd);
    endtask

    // Wait for IN_READY at a falling edge; the beat goes in on the next rising
    // edge. release_after >= 0 lifts OUT_READY after that many stalled cycles.
    task automatic wait_accept(input int release_after);
        int   t;
        logic done;
        t    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (bus.IN_READY) begin
                done = 1'b1;
            end else begin
                t++;
                if (t > 40) begin
                    check("accept_timeout", bus.IN_READY, 1);
                    bus.IN_VALID = 1'b0;
                    return;
                end
                if (t == release_after) begin
                    @(posedge CLK);
                    #1;
                    bus.OUT_READY = 1'b1;
                end
            end
        end
        exp_q.push_back(pend);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic send_dir(input logic sgn, input int a, input int b, input logic [PW-1:0] sig,
                            input logic rnd, input logic [EXP_W-1:0] e,
                            input logic [MAN_W-1:0] m, input logic [3:0] f);
        drive(sgn, a, b, sig, rnd);
        pend.sign  = sgn;
        pend.expo  = e;
        pend.man   = m;
        pend.flags = f;
        wait_accept(-1);
    endtask

    task automatic send_rand(input int release_after);
        int   a, b, ma, mb, sel;
        logic [PW-1:0] sig;
        if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 127)) - 64;
        else                           a = int'($urandom_range(0, 30)) - 20;
        if ($urandom_range(0, 3) == 0) b = int'($urandom_range(0, 127)) - 64;
        else                           b = int'($urandom_range(0, 30)) - 20;
        sel = int'($urandom_range(0, 15));
        ma  = int'($urandom_range(1024, 2047));
        mb  = int'($urandom_range(1024, 2047));
        if (sel == 1) ma = 2047;
        sig = (sel == 0) ? '0 : PW'(ma * mb);
        drive(1'($urandom_range(0, 1)), a, b, sig, 1'($urandom_range(0, 1)));
        wait_accept(release_after);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Every valid output must match the oldest outstanding beat, also while held
    always @(negedge CLK) begin
        if (!RST && bus.OUT_VALID) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", bus.OUT_VALID, 0);
            end else begin
                check("out_sign",  bus.OUT_SIGN,  exp_q[0].sign);
                check("out_exp",   bus.OUT_EXP,   exp_q[0].expo);
                check("out_man",   bus.OUT_MAN,   exp_q[0].man);
                check("out_flags", bus.OUT_FLAGS, exp_q[0].flags);
                if (bus.OUT_READY) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.IN_VALID   = 1'b0;
        bus.IN_SIGN    = 1'b0;
        bus.IN_EXP_A   = '0;
        bus.IN_EXP_B   = '0;
        bus.IN_SIG_MUL = '0;
        bus.RND_MODE   = 1'b0;
        bus.OUT_READY  = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_in_ready",  bus.IN_READY,  1);
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_out_sign",  bus.OUT_SIGN,  0);
        check("rst_out_exp",   bus.OUT_EXP,   0);
        check("rst_out_man",   bus.OUT_MAN,   0);
        check("rst_out_flags", bus.OUT_FLAGS, 0);
        RST           = 1'b0;
        bus.OUT_READY = 1'b1;
        @(posedge CLK);
        #1;

        // Latency: 1.5 * 1.5
        send_dir(0, 0, 0, 22'h240000, 0, 5'h10, 10'h080, 4'b0000);
        check("lat_0", bus.OUT_VALID, 0);
        @(negedge CLK);
        check("lat_1", bus.OUT_VALID, 0);
        @(posedge CLK);
        #1;
        check("lat_2", bus.OUT_VALID, 1);
        wait_drain();

        // Directed corners, back to back
        send_dir(1,  15,   1, 22'h100000, 0, 5'h1F, 10'h000, 4'b1001); // overflow
        send_dir(0, -14,  -1, 22'h100000, 0, 5'h00, 10'h200, 4'b0010); // exact subnormal
        send_dir(1, -14, -11, 22'h100000, 0, 5'h00, 10'h000, 4'b0101); // tie to even zero
        send_dir(0,   0,   0, 22'h100600, 0, 5'h0F, 10'h002, 4'b0001); // RNE up
        send_dir(0,   0,   0, 22'h100600, 1, 5'h0F, 10'h001, 4'b0001); // truncate
        send_dir(0,   0,   0, 22'h1FFE00, 0, 5'h10, 10'h000, 4'b0001); // rounding carry
        send_dir(1,   5,   5, 22'h000000, 0, 5'h00, 10'h000, 4'b0000); // exact zero
        send_dir(0,  15,   0, 22'h1FFE00, 0, 5'h1F, 10'h000, 4'b1001); // post-round overflow
        send_dir(0,  15,   0, 22'h1FFE00, 1, 5'h1E, 10'h3FF, 4'b0001); // max normal, truncated
        send_dir(0, -15,   0, 22'h1FFE00, 0, 5'h01, 10'h000, 4'b0001); // subnormal -> min normal
        send_dir(1, -64, -64, 22'h200000, 0, 5'h00, 10'h000, 4'b0101); // capped shift
        send_dir(0,   2,   3, 22'h3FF001, 0, 5'h15, 10'h3FE, 4'b0001); // sticky only
        wait_drain();

        // Backpressure: two beats fill the pipe, the third must stall
        n0 = n_out;
        bus.OUT_READY = 1'b0;
        send_rand(-1);
        send_rand(-1);
        drive(0, 1, 2, 22'h2A5F31, 0);
        repeat (3) begin
            @(negedge CLK);
            check("bp_in_ready", bus.IN_READY, 0);
        end
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b1;
        wait_accept(-1);
        send_rand(-1);
        wait_drain();
        check("bp_count", n_out - n0, 4);

        // Reset with two beats in flight
        send_rand(-1);
        send_rand(-1);
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("rst_flight_valid", bus.OUT_VALID, 0);
        check("rst_flight_ready", bus.IN_READY, 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_release_valid", bus.OUT_VALID, 0);
        repeat (4) begin
            @(negedge CLK);
            check("post_rst_valid", bus.OUT_VALID, 0);
        end
        @(posedge CLK);
        #1;

        // Randomized beats with random stalls and idle gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.IN_VALID = 1'b0;
                @(posedge CLK);
                #1;
            end
            bus.OUT_READY = ($urandom_range(0, 3) != 0);
            send_rand(3);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
